// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM state encoding and opcode helpers for seq_alu
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  // 10xx: bit 1 selects divide, bit 0 selects signed
  function automatic logic is_mdu(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - single-cycle combinational ALU for opcodes 0000-0111
module alu_comb_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $signed(a) >>> sh;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with registered results and iterative mul/div
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] HI,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, nstate;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic             sa, sb;
  logic [WIDTH-1:0] a_orig, mb, p_hi, p_lo;
  logic [WIDTH-1:0] core_y, ma_in, mb_in;
  logic             sa_in, sb_in;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a  (A),
    .b  (B),
    .op (ALUop),
    .y  (core_y)
  );

  assign sa_in = ALUop[0] & A[WIDTH-1];
  assign sb_in = ALUop[0] & B[WIDTH-1];
  assign ma_in = sa_in ? -A : A;
  assign mb_in = sb_in ? -B : B;

  // p_hi:p_lo is the product register for mul, remainder:quotient for div
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
  assign div_diff = {1'b0, p_hi, p_lo[WIDTH-1]} - {2'b00, mb};
  assign prod_fix = (sa ^ sb) ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign quo_fix  = (sa ^ sb) ? -p_lo : p_lo;
  assign rem_fix  = sa ? -p_hi : p_hi;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (start) nstate = is_mdu(ALUop) ? ST_CALC : ST_DONE;
      ST_CALC: if (cnt == CW'(WIDTH - 1)) nstate = ST_FIX;
      ST_FIX:  nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      C      <= '0;
      HI     <= '0;
      div0   <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_orig <= '0;
      mb     <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_q <= ALUop;
          if (is_mdu(ALUop)) begin
            sa     <= sa_in;
            sb     <= sb_in;
            a_orig <= A;
            mb     <= mb_in;
            p_hi   <= '0;
            p_lo   <= ma_in;
            cnt    <= '0;
          end else begin
            C    <= core_y;
            HI   <= '0;
            div0 <= 1'b0;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            if (!div_diff[WIDTH+1]) begin
              p_hi <= div_diff[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          if (op_q[1] && mb == '0) begin
            C    <= '1;
            HI   <= a_orig;
            div0 <= 1'b1;
          end else if (op_q[1]) begin
            C    <= quo_fix;
            HI   <= rem_fix;
            div0 <= 1'b0;
          end else begin
            {HI, C} <= prod_fix;
            div0    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
